// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event scheduler and its event queue.
//   KEY_N_DEFAULT : default number of buttons
//   key_cw(n)     : width of a key index for n keys (minimum 1 bit)
//   key_name_e    : index names of the five front-panel buttons
//   evt_kind_e    : value of the repeat flag in an event word
//   rpt_state_e   : auto-repeat tracker states
// Event word layout (CW+1 bits): {repeat, code[CW-1:0]}
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_N_DEFAULT = 5;

  function automatic int key_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum int unsigned {
    KEY_UP    = 0,
    KEY_DOWN  = 1,
    KEY_LEFT  = 2,
    KEY_RIGHT = 3,
    KEY_OK    = 4
  } key_name_e;

  typedef enum logic {
    EVT_PRESS  = 1'b0,
    EVT_REPEAT = 1'b1
  } evt_kind_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_evt_fifo.sv
// ---------------------------------------------------------------------------
// key_evt_fifo
// Synchronous first-word-fall-through FIFO for key event words.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle. A pop on an empty FIFO is ignored. The head word is presented
// combinationally and forced to zero while empty so the read port has a
// defined value straight out of reset.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, push_data_i   write request and word
//   pop_i             consume the head word
//   rd_data_o         head word (zero when empty)
//   full_o, empty_o   occupancy flags
// ---------------------------------------------------------------------------
module key_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_eff;
  logic             pop_eff;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_eff  = pop_i & ~empty_o;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push_eff = push_i & (~full_o | pop_eff);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// ---------------------------------------------------------------------------
// key_event_scheduler
// Collects one-cycle press pulses from the debouncer bank, remembers them in
// a per-key pending register, grants one pending key per cycle round-robin
// into a small FWFT event queue and presents key codes to the control FSM
// over a valid/ready handshake.
// Optional feature (macro KEY_REPEAT_EN): auto-repeat of the most recently
// granted genuine press while its key_held level stays high. Without the
// macro no repeat logic exists, evt_repeat is 0 and key_held is ignored.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   key_pulse      one-cycle press pulse per key
//   key_held       debounced level per key (auto-repeat only)
//   evt_valid      an event is presented (queue non-empty)
//   evt_ready      consumer accepts the event on valid & ready
//   evt_code       key index of the presented event
//   evt_repeat     1 = auto-repeat event, 0 = genuine press
//   overflow       sticky flag: a press was lost
//   clr_overflow   synchronous clear of overflow (a new loss wins)
// ---------------------------------------------------------------------------
module key_event_scheduler
  import key_pkg::*;
#(
  parameter  int N_KEYS       = KEY_N_DEFAULT,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int REPEAT_DELAY = 50_000_000,
  parameter  int REPEAT_RATE  = 10_000_000,
  localparam int CW           = key_cw(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_pulse,
  input  logic [N_KEYS-1:0] key_held,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CW-1:0]     evt_code,
  output logic              evt_repeat,
  output logic              overflow,
  input  logic              clr_overflow
);

  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] grant_vec;
  logic [N_KEYS-1:0] lost_vec;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              overflow_q, overflow_d;

  logic              grant_any;
  logic [CW-1:0]     grant_idx;
  logic              rep_push;
  logic [CW-1:0]     rep_code;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_accept;
  logic              fifo_push;
  logic [CW:0]       fifo_push_word;
  logic [CW:0]       fifo_rd_word;

  assign evt_valid   = ~fifo_empty;
  assign evt_code    = fifo_rd_word[CW-1:0];
  assign overflow    = overflow_q;
  assign fifo_pop    = evt_valid & evt_ready;
  assign fifo_accept = ~fifo_full | fifo_pop;

  // Round-robin search starting just after the last granted key.
  always_comb begin
    int            idx;
    logic [CW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_KEYS) idx = idx - N_KEYS;
      cand = CW'(idx);
      if (!grant_any && fifo_accept && pending_q[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // A pulse arriving with the grant of the same key is a second press and
  // stays pending; a pulse on a pending key that is not granted is lost.
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_pend
    assign grant_vec[gi] = grant_any & (grant_idx == CW'(gi));
    assign lost_vec[gi]  = key_pulse[gi] & pending_q[gi] & ~grant_vec[gi];
    assign pending_d[gi] = (pending_q[gi] & ~grant_vec[gi]) | key_pulse[gi];
  end

  assign rr_ptr_d   = grant_any ? grant_idx : rr_ptr_q;
  assign overflow_d = (|lost_vec) ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      rr_ptr_q   <= CW'(N_KEYS - 1);
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Genuine presses always win the single push slot; a repeat only uses it
  // when no key was granted.
  assign fifo_push      = grant_any | rep_push;
  assign fifo_push_word = grant_any ? {EVT_PRESS, grant_idx} : {EVT_REPEAT, rep_code};

`ifdef KEY_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNTW    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  rpt_state_e      rpt_state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   trk_q;
  logic            rep_pend_q;

  assign rep_push   = rep_pend_q & ~grant_any & fifo_accept;
  assign rep_code   = trk_q;
  assign evt_repeat = fifo_rd_word[CW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state_q <= RPT_IDLE;
      cnt_q       <= '0;
      trk_q       <= '0;
      rep_pend_q  <= 1'b0;
    end else begin
      if (rep_push) rep_pend_q <= 1'b0;
      if (grant_any) begin
        // Retarget to the newest genuine press; a stale repeat is discarded.
        rpt_state_q <= RPT_DELAY;
        cnt_q       <= '0;
        trk_q       <= grant_idx;
        rep_pend_q  <= 1'b0;
      end else begin
        case (rpt_state_q)
          RPT_DELAY: begin
            if (!key_held[trk_q]) begin
              rpt_state_q <= RPT_IDLE;
              cnt_q       <= '0;
              rep_pend_q  <= 1'b0;
            end else if (cnt_q == CNTW'(REPEAT_DELAY - 1)) begin
              rep_pend_q  <= 1'b1;
              cnt_q       <= '0;
              rpt_state_q <= RPT_REPEAT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (!key_held[trk_q]) begin
              rpt_state_q <= RPT_IDLE;
              cnt_q       <= '0;
              rep_pend_q  <= 1'b0;
            end else if (cnt_q == CNTW'(REPEAT_RATE - 1)) begin
              // Setting while still set simply coalesces.
              rep_pend_q <= 1'b1;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            rpt_state_q <= RPT_IDLE;
            cnt_q       <= '0;
          end
        endcase
      end
    end
  end
`else
  localparam int UNUSED_RPT_CFG = REPEAT_DELAY + REPEAT_RATE;
  logic unused_rpt_sig;

  assign rep_push       = 1'b0;
  assign rep_code       = '0;
  assign evt_repeat     = 1'b0;
  assign unused_rpt_sig = ^{key_held, fifo_rd_word[CW]};
`endif

  key_evt_fifo #(
    .WIDTH (CW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_word),
    .pop_i       (fifo_pop),
    .rd_data_o   (fifo_rd_word),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_key_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_key_event_scheduler
// Directed bench for key_event_scheduler (N_KEYS=5, FIFO_DEPTH=4,
// REPEAT_DELAY=20, REPEAT_RATE=8). Each table row drives one cycle of inputs
// and states the outputs expected just after the following rising edge.
// Hand-written sequences cover the asynchronous reset and auto-repeat timing.
// Repeat timing: grant at edge g, counter reaches REPEAT_DELAY-1 after edge
// g+19, rep_pend set at g+20, repeat event visible after edge g+21, then every
// REPEAT_RATE cycles.
// ---------------------------------------------------------------------------
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key_pulse = '0;
  logic [4:0] key_held = '0;
  logic       evt_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_repeat;
  logic       overflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_event_scheduler #(
    .N_KEYS       (5),
    .FIFO_DEPTH   (4),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_pulse    (key_pulse),
    .key_held     (key_held),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_repeat   (evt_repeat),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] pulse;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [2:0] code;
    logic       rep;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [4:0] pulse, input logic rdy,
                              input logic clr, input logic v, input logic [2:0] code,
                              input logic rep, input logic ovf);
    vec_t t;
    t.rst = rst; t.pulse = pulse; t.rdy = rdy; t.clr = clr;
    t.v = v; t.code = code; t.rep = rep; t.ovf = ovf;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [2:0] code,
                           input logic rep);
    chk({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, "_code"}, 32'(evt_code), 32'(code));
      chk({tag, "_rep"},  32'(evt_repeat), 32'(rep));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_pulse = '0; key_held = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(evt_valid), 0);
    chk("reset_code",  32'(evt_code), 0);
    chk("reset_rep",   32'(evt_repeat), 0);
    chk("reset_ovf",   32'(overflow), 0);
    rst_n = 1'b1;

    // rst, pulse, rdy, clr | valid, code, rep, ovf
    // single press: valid two edges after the pulse, for one cycle
    tbl.push_back(mk(0, 5'b00100, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 0));
    // simultaneous presses after reset (rr_ptr=4): 0,1,4 then burst 0,1
    tbl.push_back(mk(1, 5'b00000, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b10011, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 4, 0, 0));
    tbl.push_back(mk(0, 5'b00011, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 0));
    // backpressure: keys 0..4, FIFO holds 0..3, key 4 waits pending
    tbl.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00010, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b01000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b10000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 0, 0, 0));
    // re-press of pending key 4 with clear asserted: set wins
    tbl.push_back(mk(0, 5'b10000, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 3, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 4, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 0, 1, 0, 0, 0, 0));
    // full FIFO (0,2,3,4) with pending key 1: one-cycle ready pops and pushes
    tbl.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b01000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b10000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00010, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 3, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 4, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 0));
    // pulse coinciding with grant of the same key keeps the second press
    tbl.push_back(mk(0, 5'b00100, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 1, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      if (t.rst) rst_n = 1'b0;
      key_pulse = t.pulse; evt_ready = t.rdy; clr_overflow = t.clr;
      tick();
      $display("vec %0d: pulse=%b rdy=%b clr=%b -> valid=%b code=%0d rep=%b ovf=%b",
               i, t.pulse, t.rdy, t.clr, evt_valid, evt_code, evt_repeat, overflow);
      check_evt($sformatf("row%0d", i), t.v, t.code, t.rep);
      chk($sformatf("row%0d_ovf", i), 32'(overflow), 32'(t.ovf));
      rst_n = 1'b1;
    end
    key_pulse = '0; evt_ready = 1'b0; clr_overflow = 1'b0;

    // ---------------- reset mid-queue ----------------
    for (int k = 0; k < 5; k++) begin
      key_pulse = 5'(1 << k);
      tick();
    end
    key_pulse = '0;
    tick();
    key_pulse = 5'b10000;
    tick();
    key_pulse = '0;
    $display("pre-reset: valid=%b ovf=%b", evt_valid, overflow);
    chk("midrst_pre_valid", 32'(evt_valid), 1);
    chk("midrst_pre_ovf",   32'(overflow), 1);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%b code=%0d ovf=%b", evt_valid, evt_code, overflow);
    chk("midrst_valid", 32'(evt_valid), 0);
    chk("midrst_code",  32'(evt_code), 0);
    chk("midrst_ovf",   32'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    evt_ready = 1'b1;
    key_pulse = 5'b01000;
    tick();
    key_pulse = '0;
    check_evt("midrst_k3_wait", 0, 0, 0);
    tick();
    $display("post-reset press: valid=%b code=%0d", evt_valid, evt_code);
    check_evt("midrst_k3", 1, 3, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_evt($sformatf("midrst_quiet%0d", k), 0, 0, 0);
    end

`ifdef KEY_REPEAT_EN
    // ---------------- auto-repeat while held ----------------
    do_reset();
    evt_ready = 1'b1;
    key_held = 5'b00010; key_pulse = 5'b00010;
    tick();
    key_pulse = '0;
    tick();
    $display("repeat c=0: valid=%b code=%0d rep=%b", evt_valid, evt_code, evt_repeat);
    check_evt("rpt_c0", 1, 1, 0);
    for (int c = 1; c <= 80; c++) begin
      logic ev;
      if (c == 57) key_held = '0;
      tick();
      ev = (c == 21) || (c == 29) || (c == 37) || (c == 45) || (c == 53);
      if (ev) $display("repeat c=%0d: valid=%b code=%0d rep=%b", c, evt_valid, evt_code, evt_repeat);
      check_evt($sformatf("rpt_c%0d", c), ev, 1, 1);
    end

    // ---------------- retarget to a newer press ----------------
    do_reset();
    evt_ready = 1'b1;
    key_held = 5'b00010; key_pulse = 5'b00010;
    tick();
    key_pulse = '0;
    tick();
    check_evt("rtg_c0", 1, 1, 0);
    for (int c = 1; c <= 65; c++) begin
      logic       ev;
      logic       er;
      key_pulse = (c == 11) ? 5'b01000 : 5'b00000;
      if (c == 11) key_held = 5'b01010;
      if (c == 50) key_held = '0;
      tick();
      ev = (c == 12) || (c == 33) || (c == 41) || (c == 49);
      er = (c != 12);
      if (ev) $display("retarget c=%0d: valid=%b code=%0d rep=%b", c, evt_valid, evt_code, evt_repeat);
      check_evt($sformatf("rtg_c%0d", c), ev, 3, er);
    end
    key_pulse = '0;
`else
    // ---------------- no repeat without the feature ----------------
    do_reset();
    evt_ready = 1'b1;
    key_held = 5'b00010; key_pulse = 5'b00010;
    tick();
    key_pulse = '0;
    tick();
    $display("hold c=0: valid=%b code=%0d rep=%b", evt_valid, evt_code, evt_repeat);
    check_evt("norpt_c0", 1, 1, 0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      check_evt($sformatf("norpt_c%0d", c), 0, 0, 0);
    end
    key_held = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
